// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the keypad matrix scanner.
// Event direction encoding and a minimum-one-bit width helper.
package keypad_pkg;

  localparam logic KEY_RELEASE = 1'b0;
  localparam logic KEY_PRESS   = 1'b1;

  // Bits needed to index n items; never less than one bit.
  function automatic int code_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: a stable bit that flips only after DEBOUNCE_SCANS
// consecutive samples disagree with it; toggle is high on the accepting sample.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic sample_en,
  output logic stable,
  output logic toggle
);

  localparam int CNT_W = code_width(DEBOUNCE_SCANS);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stable_reg, stable_next;

  always_comb begin
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    toggle      = 1'b0;
    if (sample_en) begin
      if (sample == stable_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_SCANS - 1)) begin
        toggle      = 1'b1;
        stable_next = ~stable_reg;
        cnt_next    = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Scanned, debounced row/column keypad matrix reader with press/release
// event strobes and a live key map.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_CYCLES    = 8,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ROWS-1:0]                     rows,
  output logic [COLS-1:0]                     cols,
  output logic                                key_valid,
  output logic [code_width(ROWS*COLS)-1:0]    key_code,
  output logic                                key_press,
  output logic [ROWS*COLS-1:0]                key_state
);

  localparam int NK = ROWS * COLS;
  localparam int CW = code_width(NK);
  localparam int DW = code_width(SCAN_CYCLES);
  localparam int IW = code_width(COLS);

  logic [ROWS-1:0] rows_meta_reg, rows_sync_reg;
  logic [DW-1:0]   dwell_reg;
  logic [IW-1:0]   col_reg, col_next;
  logic            sample_edge;
  logic [NK-1:0]   stable, toggle;
  logic [ROWS-1:0] row_toggle;
  logic [ROWS-1:0] pend_reg, pend_next, pend_dir_reg;
  logic [IW-1:0]   pend_col_reg;
  logic            found;
  int              low_row;
  logic [CW-1:0]   code_reg, code_next;
  logic            press_reg, press_next, valid_reg;

  assign sample_edge = (dwell_reg == DW'(SCAN_CYCLES - 1));
  assign col_next    = (col_reg == IW'(COLS - 1)) ? '0 : col_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NK; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
        .clk      (clk),
        .rst      (rst),
        .sample   (rows_sync_reg[gi / COLS]),
        .sample_en(sample_edge && (col_reg == IW'(gi % COLS))),
        .stable   (stable[gi]),
        .toggle   (toggle[gi])
      );
    end
  endgenerate

  always_comb begin
    cols       = '0;
    row_toggle = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_reg == IW'(c)) begin
        cols[c] = 1'b1;
        for (int r = 0; r < ROWS; r++) row_toggle[r] = toggle[r * COLS + c];
      end
    end
  end

  // Emitter: pick the lowest pending row and retire it this cycle.
  always_comb begin
    found     = 1'b0;
    low_row   = 0;
    pend_next = pend_reg;
    for (int r = 0; r < ROWS; r++) begin
      if (pend_reg[r] && !found) begin
        found   = 1'b1;
        low_row = r;
      end
    end
    if (found) pend_next[low_row] = 1'b0;
    code_next  = CW'(low_row * COLS + int'(pend_col_reg));
    press_next = pend_dir_reg[low_row];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_meta_reg <= '0;
      rows_sync_reg <= '0;
      dwell_reg     <= '0;
      col_reg       <= '0;
      pend_reg      <= '0;
      pend_dir_reg  <= '0;
      pend_col_reg  <= '0;
      valid_reg     <= 1'b0;
      code_reg      <= '0;
      press_reg     <= KEY_RELEASE;
    end else begin
      rows_meta_reg <= rows;
      rows_sync_reg <= rows_meta_reg;
      if (sample_edge) begin
        dwell_reg    <= '0;
        col_reg      <= col_next;
        pend_reg     <= row_toggle;
        pend_dir_reg <= rows_sync_reg;
        pend_col_reg <= col_reg;
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
        pend_reg  <= pend_next;
      end
      valid_reg <= found;
      if (found) begin
        code_reg  <= code_next;
        press_reg <= press_next;
      end
    end
  end

  assign key_valid = valid_reg;
  assign key_code  = code_reg;
  assign key_press = press_reg;
  assign key_state = stable;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus randomized key/bounce
// stimulus checked every cycle against a scan-schedule reference model.
module tb_keypad_scanner;

  localparam int ROWS = 4, COLS = 4, SC = 8, DB = 3;
  localparam int NK = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ROWS-1:0] rows = '0;
  logic [COLS-1:0] cols;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            key_press;
  logic [NK-1:0]   key_state;

  logic       rst2 = 1'b1;
  logic [0:0] rows2 = 1'b0;
  logic [0:0] cols2;
  logic       key_valid2;
  logic [0:0] key_code2;
  logic       key_press2;
  logic [0:0] key_state2;

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .key_valid(key_valid),
    .key_code(key_code), .key_press(key_press), .key_state(key_state)
  );

  keypad_scanner #(.ROWS(1), .COLS(1), .SCAN_CYCLES(3), .DEBOUNCE_SCANS(1)) dut2 (
    .clk(clk), .rst(rst2), .rows(rows2), .cols(cols2), .key_valid(key_valid2),
    .key_code(key_code2), .key_press(key_press2), .key_state(key_state2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: n counts clock edges since reset release; the column
  // scanned in cycle n is (n/SC)%COLS and that column is sampled at edge n
  // when n%SC == SC-1, using the row levels present two edges earlier.
  int              n;
  bit              stable_m[NK];
  int              cnt_m[NK];
  logic [ROWS-1:0] hist[$];
  int              ev_code[int];
  bit              ev_press[int];
  bit              held[ROWS][COLS];
  int              glitch_pct = 0;

  typedef struct {int edge_n; int code; bit press;} obs_t;
  obs_t obs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < NK; i++) begin
      stable_m[i] = 1'b0;
      cnt_m[i]    = 0;
    end
    hist.delete();
    ev_code.delete();
    ev_press.delete();
  endtask

  task automatic model_step();
    logic [ROWS-1:0] s;
    int c, k, key;
    s = (hist.size() == 2) ? hist[0] : '0;
    hist.push_back(rows);
    if (hist.size() > 2) void'(hist.pop_front());
    if (n % SC == SC - 1) begin
      c = (n / SC) % COLS;
      k = 0;
      for (int r = 0; r < ROWS; r++) begin
        key = r * COLS + c;
        if (s[r] != stable_m[key]) begin
          cnt_m[key]++;
          if (cnt_m[key] == DB) begin
            stable_m[key] = !stable_m[key];
            cnt_m[key] = 0;
            ev_code[n + 1 + k]  = key;
            ev_press[n + 1 + k] = stable_m[key];
            k++;
          end
        end else begin
          cnt_m[key] = 0;
        end
      end
    end
    n++;
  endtask

  task automatic compare();
    int m;
    bit exp_v;
    logic [NK-1:0] exp_state;
    m = n - 1;
    for (int i = 0; i < NK; i++) exp_state[i] = stable_m[i];
    chk("cols", int'(cols), 1 << (((m + 1) / SC) % COLS));
    exp_v = ev_code.exists(m);
    chk("key_valid", int'(key_valid), int'(exp_v));
    if (exp_v) begin
      chk("key_code", int'(key_code), ev_code[m]);
      chk("key_press", int'(key_press), int'(ev_press[m]));
      ev_code.delete(m);
      ev_press.delete(m);
    end
    chk("key_state", int'(key_state), int'(exp_state));
    if (key_valid) begin
      obs.push_back('{m, int'(key_code), key_press});
      $display("event edge=%0d code=%0d press=%0d", m, key_code, key_press);
    end
  endtask

  task automatic drive();
    int c;
    logic [ROWS-1:0] v;
    c = (n / SC) % COLS;
    for (int r = 0; r < ROWS; r++) v[r] = held[r][c];
    if (glitch_pct > 0 && int'($urandom_range(99)) < glitch_pct)
      v[$urandom_range(ROWS - 1)] ^= 1'b1;
    rows = v;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      drive();
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_cols", int'(cols), 1);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_state", int'(key_state), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive();
  endtask

  task automatic clear_held();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) held[r][c] = 1'b0;
  endtask

  initial begin
    bit pat[6];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    clear_held();
    repeat (2) @(negedge clk);
    chk("init_cols", int'(cols), 1);
    chk("init_valid", int'(key_valid), 0);
    chk("init_state", int'(key_state), 0);
    rst = 1'b0;
    model_reset();
    drive();

    // Clean press of key 6 (row 1, col 2), then release.
    held[1][2] = 1'b1;
    obs.delete();
    run(128);
    chk("clean_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("clean_code", obs[0].code, 6);
      chk("clean_press", int'(obs[0].press), 1);
      chk("clean_edge", obs[0].edge_n, 88);
    end
    chk("clean_map", int'(key_state), 'h0040);
    held[1][2] = 1'b0;
    obs.delete();
    run(128);
    chk("release_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("release_code", obs[0].code, 6);
      chk("release_press", int'(obs[0].press), 0);
      chk("release_edge", obs[0].edge_n, 216);
    end

    // Bounce: 2 high samples, 1 low, then 3 high.
    obs.delete();
    for (int j = 0; j < 6; j++) begin
      held[1][2] = pat[j];
      run(32);
    end
    chk("bounce_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("bounce_code", obs[0].code, 6);
      chk("bounce_edge", obs[0].edge_n, 440);
    end
    held[1][2] = 1'b0;
    run(128);

    // Simultaneous presses in column 1, rows 0 and 3.
    held[0][1] = 1'b1;
    held[3][1] = 1'b1;
    obs.delete();
    run(128);
    chk("simul_count", obs.size(), 2);
    if (obs.size() >= 2) begin
      chk("simul_code0", obs[0].code, 1);
      chk("simul_code1", obs[1].code, 13);
      chk("simul_edge0", obs[0].edge_n, 656);
      chk("simul_edge1", obs[1].edge_n, 657);
    end
    clear_held();
    run(128);

    // Reset mid-scan while key 6 is held: no release, then a fresh press.
    held[1][2] = 1'b1;
    run(128);
    chk("hold_map", int'(key_state), 'h0040);
    run(13);
    obs.delete();
    do_reset();
    run(128);
    chk("rehold_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("rehold_code", obs[0].code, 6);
      chk("rehold_press", int'(obs[0].press), 1);
      chk("rehold_edge", obs[0].edge_n, 88);
    end
    clear_held();
    run(128);

    // Randomized key activity with row glitches.
    glitch_pct = 15;
    for (int s = 0; s < 60; s++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if ($urandom_range(9) == 0) held[r][c] = !held[r][c];
      run(32);
    end
    glitch_pct = 0;
    clear_held();
    run(128);

    // Degenerate 1x1 matrix with single-sample debounce.
    rows2 = 1'b1;
    rst2  = 1'b0;
    for (int m = 0; m < 9; m++) begin
      @(posedge clk);
      @(negedge clk);
      chk("tiny_cols", int'(cols2), 1);
      chk("tiny_valid", int'(key_valid2), (m == 3) ? 1 : 0);
      chk("tiny_state", int'(key_state2), (m >= 2) ? 1 : 0);
      if (m == 3) begin
        chk("tiny_code", int'(key_code2), 0);
        chk("tiny_press", int'(key_press2), 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised row/column keypad matrix scanner for the Pacman board: drives one column at a time, samples the row inputs, debounces every key independently, and reports press and release events as single-cycle code pulses for the game-control logic. Generalises the fixed 4×4 combinational row/column decode into a clocked, scanned, debounced interface of arbitrary matrix size, with event reporting and a live key map.

## Interface
- ROWS, 4, number of row inputs (≥1)
- COLS, 4, number of driven columns (≥1)
- SCAN_CYCLES, 8, clock cycles each column is driven; must be ≥ ROWS+2
- DEBOUNCE_SCANS, 3, consecutive differing samples needed to accept a key change (≥1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rows  in  ROWS  raw row lines, active-high (pull-downs on board), asynchronous to clk
- cols  out  COLS  one-hot column drive, active-high
- key_valid  out  1  one-cycle event strobe
- key_code  out  $clog2(ROWS*COLS) (min 1)  key index = row*COLS + col, valid with key_valid
- key_press  out  1  1 = press event, 0 = release event, valid with key_valid
- key_state  out  ROWS*COLS  debounced map, bit row*COLS+col = 1 while held

## Operation
- rows passes through a 2-flop synchroniser before any use.
- Dwell counter counts 0..SCAN_CYCLES-1 per column; at SCAN_CYCLES-1 the synchronised rows are sampled for the current column, then the column index advances (COLS-1 wraps to 0) and cols updates on the same edge.
- Per key: stable bit plus counter. Sample == stable → counter cleared. Sample != stable → counter +1; when the count reaches DEBOUNCE_SCANS, stable toggles and counter clears. A bounce back to the stable value before acceptance clears the counter.
- Each toggle sets that row's bit in a ROWS-wide pending mask (loaded at the sample edge, direction recorded per row). The emitter drains the mask one bit per cycle, lowest row first, on the cycles following the sample; SCAN_CYCLES ≥ ROWS+2 guarantees the mask is empty before the next sample.
- key_state reflects the stable bits directly.
- Simultaneous changes in one column: one event per row, ascending row order, consecutive cycles. Changes in different columns are never simultaneous.
- Reset mid-operation: all debounce state, pending events and the map are discarded; no release events are generated for keys held at reset.

## Timing
- Reset values: cols = 1 (column 0), key_valid 0, key_code 0, key_press 0, key_state 0, all counters and the pending mask 0.
- Full scan period = COLS*SCAN_CYCLES cycles.
- Row change to first sample: 2 synchroniser cycles plus wait for the column's sample slot.
- Acceptance occurs at the DEBOUNCE_SCANS-th consecutive differing sample of that key's column. key_state updates on the edge after that sample.
- The k-th pending row (k = 0 first) pulses key_valid at sample+1+k.
- key_valid is never asserted for two consecutive cycles with the same code.

## Structure
- Package keypad_pkg: code-width function (clog2 with min 1), event direction constants KEY_RELEASE = 0 and KEY_PRESS = 1.
- Sub-module key_debounce: one instance per key (stable bit + counter, inputs sample/sample_en, outputs stable/toggle), generated ROWS*COLS times.
- The top level holds the synchroniser, the dwell/column counters, the pending mask and the emitter.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=4, SCAN_CYCLES=8, DEBOUNCE_SCANS=3.
- Reset: assert rst asynchronously mid-scan → cols=4'b0001, key_valid=0, key_state=0 immediately. After release, cols rotates 0001→0010→0100→1000→0001 every 8 cycles.
- Clean press: row 1 high whenever col 2 is driven, for 4 scans → exactly one pulse: key_valid, key_code=6, key_press=1, one cycle after the 3rd col-2 sample. key_state[6]=1. Removing it yields one release pulse, code 6, key_press=0, after 3 more samples.
- Bounce: row 1 at col 2 high for 2 samples, low for 1, then high for 3 → no event until the 3rd of the final run; exactly one press event, code 6.
- Simultaneous: rows 0 and 3 both pressed at col 1 → press codes 1 then 13 on consecutive cycles, at sample+1 and sample+2.
- Reset during hold: key 6 held and accepted, rst pulsed → key_state=0, no release event. Key still held → a new press event for code 6 after 3 further samples.
- Edge parameters: DEBOUNCE_SCANS=1, ROWS=1, COLS=1 → cols constantly 1; a press is reported one cycle after the first sample.
